// File: rtl/demux4_stream.sv
// demux4_stream: registered 1-to-4 stream demultiplexer with valid/ready.
// Each input beat is steered by in_sel into a one-entry holding register
// on the selected lane; every lane drains independently under its own ready.
// Optional feature macro: DEMUX4_COUNT_EN adds 8-bit per-lane accept counters
// (lane_cnt0..lane_cnt3). Without it the counter ports and logic are absent.

module demux4_lane #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             rdy,
  input  logic [WIDTH-1:0] d,
`ifdef DEMUX4_COUNT_EN
  output logic [7:0]       cnt,
`endif
  output logic [WIDTH-1:0] q,
  output logic             vld
);

  // Holding register: a load wins over a drain, so a same-cycle
  // drain+load keeps the lane full with the new beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q   <= '0;
      vld <= 1'b0;
    end else if (load) begin
      q   <= d;
      vld <= 1'b1;
    end else if (vld && rdy) begin
      vld <= 1'b0;
    end
  end

`ifdef DEMUX4_COUNT_EN
  // Accepted-beat counter; free-running 8-bit wrap, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n)    cnt <= '0;
    else if (load) cnt <= cnt + 8'd1;
  end
`endif

endmodule

module demux4_stream #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [3:0]       out_valid,
`ifdef DEMUX4_COUNT_EN
  output logic [7:0]       lane_cnt0,
  output logic [7:0]       lane_cnt1,
  output logic [7:0]       lane_cnt2,
  output logic [7:0]       lane_cnt3,
`endif
  input  logic [3:0]       out_ready
);

  localparam int NUM_LANES = 4;

  logic                              accept;
  logic [NUM_LANES-1:0]              load;
  logic [NUM_LANES-1:0][WIDTH-1:0]   lane_q;
`ifdef DEMUX4_COUNT_EN
  logic [NUM_LANES-1:0][7:0]         lane_cnt;
`endif

  // Ready depends only on the targeted lane, never on in_valid, and is
  // forced low through the whole reset cycle.
  assign in_ready = rst_n && (!out_valid[in_sel] || out_ready[in_sel]);
  assign accept   = in_valid && in_ready;
  assign load     = {NUM_LANES{accept}} & (4'b0001 << in_sel);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    demux4_lane #(.WIDTH(WIDTH)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[g]),
      .rdy   (out_ready[g]),
      .d     (in_data),
`ifdef DEMUX4_COUNT_EN
      .cnt   (lane_cnt[g]),
`endif
      .q     (lane_q[g]),
      .vld   (out_valid[g])
    );
  end

  assign out0 = lane_q[0];
  assign out1 = lane_q[1];
  assign out2 = lane_q[2];
  assign out3 = lane_q[3];

`ifdef DEMUX4_COUNT_EN
  assign lane_cnt0 = lane_cnt[0];
  assign lane_cnt1 = lane_cnt[1];
  assign lane_cnt2 = lane_cnt[2];
  assign lane_cnt3 = lane_cnt[3];
`endif

endmodule

// File: doc/demux4_stream.md
# demux4_stream

Registered 1-to-4 stream demultiplexer with valid/ready handshakes. It is the distribution-side counterpart to the team's 4:1 nibble multiplexer. Each beat on the single input port carries a 2-bit `select` and is routed into a one-entry holding register on the chosen output lane. Each lane drains independently under its own ready. The block sits between a shared producer and four independent consumers.

## Interface
Parameters:
- `WIDTH`, default 4: data width of the input and of every output lane.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `in_data` in WIDTH: input beat payload.
- `in_sel` in 2: destination lane of the input beat (0..3).
- `in_valid` in 1: input beat present.
- `in_ready` out 1: the block accepts a beat this cycle.
- `out0`..`out3` out WIDTH each: lane payload registers.
- `out_valid` out 4: bit n means lane n holds a beat.
- `out_ready` in 4: bit n means consumer n takes the beat this cycle.
- `lane_cnt0`..`lane_cnt3` out 8 each: present only with `DEMUX4_COUNT_EN`; per-lane accepted-beat count.

## Operation
- Per lane n: data register `outn` and full flag `out_valid[n]`.
- Accept condition: `in_valid && in_ready`.
- `in_ready = rst_n && (!out_valid[in_sel] || out_ready[in_sel])`. This is combinational on `in_sel` and `out_ready`. It never depends on `in_valid`.
- On accept to lane s:
  - `outs <= in_data`
  - `out_valid[s] <= 1`
- Drain of lane n (`out_valid[n] && out_ready[n]`) with no accept to n: `out_valid[n] <= 0`. `outn` holds its last value.
- Drain and accept on the same lane in the same cycle:
  - The new beat is loaded and `out_valid` stays 1.
  - The old beat is counted as consumed.
- Drains on other lanes proceed independently in the same cycle as an accept. Up to 4 drains and 1 accept can occur per cycle.
- A stalled input beat (`in_valid=1`, `in_ready=0`) must be held stable by the producer.
- The block does not reorder beats within a lane. There is no ordering guarantee across lanes.
- `out_ready[n]` while `out_valid[n]=0` is ignored.

## Timing
- Reset (cycle with `rst_n=0` at the edge):
  - `out_valid=4'b0000`
  - `out0`..`out3` = 0
  - `lane_cnt*` = 0
  - `in_ready` is 0 for the whole cycle in which `rst_n` is low.
- Reset mid-operation discards all buffered beats. A beat presented during the reset cycle is not accepted.
- Latency: a beat accepted at edge k is visible on `outs` with `out_valid[s]=1` after edge k. The earliest drain is at edge k+1.
- Throughput:
  - 1 beat/cycle to a single lane if that lane's consumer holds `out_ready=1`.
  - Round-robin across lanes also sustains 1 beat/cycle.
- Full lane with `out_ready=0`: `in_ready=0` only when `in_sel` targets that lane. Beats to other lanes still flow.

## Configuration
- `DEMUX4_COUNT_EN` defined:
  - Ports `lane_cnt0`..`lane_cnt3` exist.
  - `lane_cntn` increments by 1 on every accept to lane n.
  - It is 8-bit, wraps 255 -> 0 and never saturates.
  - It clears only on reset.
- Not defined: the counter ports and logic are absent. Datapath behaviour is identical.

## Test plan
- Reset then idle: after reset `out_valid=0000`, all outputs 0 and `in_ready=1`. With `rst_n=0` the bench drives `in_valid=1`, and `in_ready` must be 0 with nothing loaded.
- Single beat: `in_data=4'hA`, `in_sel=2`, `out_ready=0000` -> next cycle `out2=A`, `out_valid=0100`. A second beat to lane 2 sees `in_ready=0`. The same beat retargeted to `in_sel=0` is accepted.
- Same-cycle drain and load:
  - Lane 1 holds 3, `out_ready=0010`, input 5 to lane 1.
  - Required: `in_ready=1`; next cycle `out1=5`, `out_valid[1]=1`; beat 3 is consumed exactly once.
- Streaming: 16 beats 0..F cycling `in_sel` 0,1,2,3, all `out_ready=1`.
  - Required: `in_ready` is 1 every cycle.
  - Each lane sees its 4 values in order: lane 0 gets 0,4,8,C.
- Reset mid-stream: lanes 0 and 3 full and `rst_n` pulsed low one cycle -> `out_valid=0000` and outputs 0. No stale beat appears afterwards.
- `DEMUX4_COUNT_EN`: 257 accepts to lane 3 -> `lane_cnt3=1`, other counters 0. Without the macro the same stimulus compiles and the data outputs match.
